// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

    // Register-address width for a given architectural register count.
    function automatic int unsigned addr_bits(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Port-B writeback FIFO: circular buffer with per-entry valid/reg view for hazard lookup.
module wb_fifo #(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned ADDR    = 5,
    parameter  int unsigned B_DEPTH = 2,
    localparam int unsigned PTR_W   = $clog2(B_DEPTH),
    localparam int unsigned CNT_W   = PTR_W + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [ADDR-1:0]               push_reg,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [CNT_W-1:0]              count,
    output logic [ADDR-1:0]               head_reg_c,
    output logic [WIDTH-1:0]              head_data_c,
    output logic [B_DEPTH-1:0]            ent_valid_c,
    output logic [B_DEPTH-1:0][ADDR-1:0]  ent_reg_c
);

    logic [ADDR-1:0]  mem_reg  [B_DEPTH];
    logic [WIDTH-1:0] mem_data [B_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < B_DEPTH; i++) begin
                mem_reg[i]  <= '0;
                mem_data[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr]  <= push_reg;
                mem_data[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry and occupancy map (slot valid when its distance from rd_ptr < count).
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        head_reg_c  = mem_reg[rd_ptr];
        head_data_c = mem_data[rd_ptr];
        ent_valid_c = '0;
        ent_reg_c   = '0;
        for (int unsigned i = 0; i < B_DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            ent_valid_c[i] = CNT_W'(offset) < count;
            ent_reg_c[i]   = mem_reg[i];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between pipeline (A) and buffered long-latency (B) writebacks.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned B_DEPTH  = 2,
    parameter  int unsigned MAX_WAIT = 4,
    localparam int unsigned ADDR     = addr_bits(DEPTH),
    localparam int unsigned CNT_W    = $clog2(B_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [ADDR-1:0]  a_reg,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [ADDR-1:0]  b_reg,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic [CNT_W-1:0] b_count,
    input  logic [ADDR-1:0]  q_reg,
    output logic             q_hit,
    output logic             regwrite,
    output logic [ADDR-1:0]  wreg,
    output logic [WIDTH-1:0] wdata
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]               count;
    logic [ADDR-1:0]                head_reg;
    logic [WIDTH-1:0]               head_data;
    logic [B_DEPTH-1:0]             ent_valid;
    logic [B_DEPTH-1:0][ADDR-1:0]   ent_reg;
    logic [WAIT_W-1:0]              wait_cnt;
    logic                           push;
    logic                           force_b;
    grant_e                         grant;
    logic [ADDR-1:0]                sel_reg;
    logic [WIDTH-1:0]               sel_data;

    assign b_ready = count < CNT_W'(B_DEPTH);
    assign push    = b_valid && b_ready;
    assign b_count = count;

    wb_fifo #(
        .WIDTH   (WIDTH),
        .ADDR    (ADDR),
        .B_DEPTH (B_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_reg    (b_reg),
        .push_data   (b_data),
        .pop         (grant == GNT_B),
        .count       (count),
        .head_reg_c  (head_reg),
        .head_data_c (head_data),
        .ent_valid_c (ent_valid),
        .ent_reg_c   (ent_reg)
    );

    // Grant selection: A has priority unless B has waited MAX_WAIT A-grants.
    always_comb begin
        grant    = GNT_NONE;
        sel_reg  = a_reg;
        sel_data = a_data;
        force_b  = (count != '0) && (wait_cnt == WAIT_W'(MAX_WAIT));
        if ((count != '0) && (!a_valid || force_b)) begin
            grant    = GNT_B;
            sel_reg  = head_reg;
            sel_data = head_data;
        end else if (a_valid) begin
            grant = GNT_A;
        end
        a_ready = !force_b;
    end

    // Starvation counter: counts A-grants taken while B entries are waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((count == '0) || (grant == GNT_B)) begin
            wait_cnt <= '0;
        end else if ((grant == GNT_A) && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered write port; writes to $0 are consumed without asserting regwrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite <= 1'b0;
            wreg     <= '0;
            wdata    <= '0;
        end else if (grant != GNT_NONE) begin
            regwrite <= (sel_reg != '0);
            wreg     <= sel_reg;
            wdata    <= sel_data;
        end else begin
            regwrite <= 1'b0;
        end
    end

    // Hazard query: pending write to q_reg in the FIFO or the output stage.
    always_comb begin
        q_hit = 1'b0;
        if (q_reg != '0) begin
            for (int unsigned i = 0; i < B_DEPTH; i++) begin
                if (ent_valid[i] && (ent_reg[i] == q_reg)) begin
                    q_hit = 1'b1;
                end
            end
            if (regwrite && (wreg == q_reg)) begin
                q_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed writes, expected commits queued, monitor checks regwrite.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic [1:0]  b_count;
    logic [4:0]  q_reg;
    logic        q_hit;
    logic        regwrite;
    logic [4:0]  wreg;
    logic [31:0] wdata;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_vec = 0;
    int  n_err = 0;

    regfile_wb_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_reg    (a_reg),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_reg    (b_reg),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .b_count  (b_count),
        .q_reg    (q_reg),
        .q_hit    (q_hit),
        .regwrite (regwrite),
        .wreg     (wreg),
        .wdata    (wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e = {r, d};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every asserted regwrite must match the oldest expected commit.
    always @(negedge clk) begin
        if (!reset && regwrite) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got $%0d <= 0x%0h, expected no write", wreg, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ((wreg !== mon_e.r) || (wdata !== mon_e.d)) begin
                    n_err++;
                    $display("FAIL wb_commit: got $%0d <= 0x%0h, expected $%0d <= 0x%0h",
                             wreg, wdata, mon_e.r, mon_e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;
        q_reg   = '0;
        #2;
        chk("por_regwrite", 32'(regwrite), 32'd0);
        chk("por_b_count",  32'(b_count),  32'd0);
        chk("por_b_ready",  32'(b_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Test 1: build 2 FIFO entries and wait_cnt = 3, then reset mid-stream
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h100;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h200;
        expect_wr(5'd1, 32'h100);
        tick();
        a_data = 32'h101; b_reg = 5'd4; b_data = 32'h400;
        expect_wr(5'd1, 32'h101);
        tick();
        b_valid = 1'b0; a_data = 32'h102;
        expect_wr(5'd1, 32'h102);
        tick();
        a_data = 32'h103;
        #1;
        chk("t1_b_count_full", 32'(b_count), 32'd2);
        chk("t1_b_ready_full", 32'(b_ready), 32'd0);
        tick();
        reset = 1'b1; a_valid = 1'b0;
        #1;
        chk("t1_rst_regwrite", 32'(regwrite), 32'd0);
        chk("t1_rst_wreg",     32'(wreg),     32'd0);
        chk("t1_rst_wdata",    wdata,         32'd0);
        chk("t1_rst_b_count",  32'(b_count),  32'd0);
        chk("t1_rst_b_ready",  32'(b_ready),  32'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("t1_post_rst_regwrite", 32'(regwrite), 32'd0);

        // Test 2: port A only, then a write to $0
        a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hDEADBEEF;
        #1 chk("t2_a_ready", 32'(a_ready), 32'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        chk("t2_regwrite", 32'(regwrite), 32'd1);
        chk("t2_wreg",     32'(wreg),     32'd5);
        chk("t2_wdata",    wdata,         32'hDEADBEEF);
        a_reg = 5'd0; a_data = 32'h12345678;
        #1 chk("t2_a_ready_r0", 32'(a_ready), 32'd1);
        tick();
        chk("t2_r0_regwrite", 32'(regwrite), 32'd0);
        chk("t2_r0_wreg",     32'(wreg),     32'd0);

        // Test 3: B with A idle; second B entry targets $0
        a_valid = 1'b0;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h11; q_reg = 5'd7;
        #1 chk("t3_qhit_n", 32'(q_hit), 32'd0);
        tick();
        b_reg = 5'd0; b_data = 32'h22;
        #1;
        chk("t3_qhit_n1",   32'(q_hit),   32'd1);
        chk("t3_b_count_1", 32'(b_count), 32'd1);
        expect_wr(5'd7, 32'h11);
        tick();
        b_valid = 1'b0;
        #1 chk("t3_qhit_n2", 32'(q_hit), 32'd1);
        q_reg = 5'd0;
        #1;
        chk("t3_qhit_r0",     32'(q_hit),   32'd0);
        chk("t3_b_count_r0",  32'(b_count), 32'd1);
        tick();
        q_reg = 5'd7;
        #1;
        chk("t3_qhit_n3",     32'(q_hit),    32'd0);
        chk("t3_r0_regwrite", 32'(regwrite), 32'd0);
        chk("t3_b_count_0",   32'(b_count),  32'd0);

        // Test 4: starvation bound with A continuously busy
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'hA0;
        b_valid = 1'b1; b_reg = 5'd11; b_data = 32'hB0;
        expect_wr(5'd10, 32'hA0);
        tick();
        b_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            a_data = 32'hA0 + 32'(i);
            #1 chk("t4_a_ready_pre", 32'(a_ready), 32'd1);
            expect_wr(5'd10, 32'hA0 + 32'(i));
            tick();
        end
        a_data = 32'hA5;
        #1 chk("t4_a_ready_forced", 32'(a_ready), 32'd0);
        expect_wr(5'd11, 32'hB0);
        tick();
        #1;
        chk("t4_a_ready_resume", 32'(a_ready), 32'd1);
        chk("t4_b_count",        32'(b_count), 32'd0);
        expect_wr(5'd10, 32'hA5);
        tick();
        a_valid = 1'b0;
        tick();

        // Tests 5/6: backpressure, push+pop at count 1, order across pointer wrap
        a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hC0;
        b_valid = 1'b1; b_reg = 5'd13; b_data = 32'hD0;
        #1 chk("t5_b_ready_p0", 32'(b_ready), 32'd1);
        expect_wr(5'd12, 32'hC0);
        tick();
        a_data = 32'hC1; b_reg = 5'd14; b_data = 32'hD1;
        #1;
        chk("t5_b_ready_p1", 32'(b_ready), 32'd1);
        chk("t5_a_ready_p1", 32'(a_ready), 32'd1);
        expect_wr(5'd12, 32'hC1);
        tick();
        a_valid = 1'b0; b_reg = 5'd15; b_data = 32'hD2; q_reg = 5'd14;
        #1;
        chk("t5_b_ready_full", 32'(b_ready), 32'd0);
        chk("t5_b_count_full", 32'(b_count), 32'd2);
        chk("t5_qhit_second",  32'(q_hit),   32'd1);
        expect_wr(5'd13, 32'hD0);
        tick();
        q_reg = 5'd13;
        #1;
        chk("t5_b_count_after_pop", 32'(b_count), 32'd1);
        chk("t5_b_ready_after_pop", 32'(b_ready), 32'd1);
        chk("t5_qhit_outstage",     32'(q_hit),   32'd1);
        expect_wr(5'd14, 32'hD1);
        tick();
        b_reg = 5'd16; b_data = 32'hD3;
        #1 chk("t6_b_count_pushpop1", 32'(b_count), 32'd1);
        expect_wr(5'd15, 32'hD2);
        tick();
        b_reg = 5'd17; b_data = 32'hD4;
        q_reg = 5'd15;
        #1 chk("t6_qhit_outstage", 32'(q_hit), 32'd1);
        q_reg = 5'd16;
        #1 chk("t6_qhit_fifo", 32'(q_hit), 32'd1);
        q_reg = 5'd17;
        #1;
        chk("t6_qhit_not_yet",     32'(q_hit),   32'd0);
        chk("t6_b_count_pushpop2", 32'(b_count), 32'd1);
        expect_wr(5'd16, 32'hD3);
        tick();
        b_reg = 5'd18; b_data = 32'hD5;
        expect_wr(5'd17, 32'hD4);
        tick();
        b_valid = 1'b0;
        #1 chk("t6_b_count_last", 32'(b_count), 32'd1);
        expect_wr(5'd18, 32'hD5);
        tick();
        #1;
        chk("t6_b_count_empty", 32'(b_count), 32'd0);
        chk("t6_b_ready_empty", 32'(b_ready), 32'd1);
        tick();
        tick();
        @(negedge clk);
        #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
